// File: rtl/mult_27x19_arbiter.sv
// ---------------------------------------------------------------------------
// mult_27x19_arbiter
//
// Purpose: shares one external pipelined 27x19 signed multiplier among
// NUM_REQ requesters. Each cycle a round-robin arbiter accepts at most one
// operand pair and registers it onto m_ain/m_bin. A tag pipeline tracks which
// requester owns each in-flight product, and returns that product on
// rsp_pout with a one-hot rsp_valid strobe once the multiplier's latency has
// elapsed.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - synchronous active-high reset
//   req_valid  - [NUM_REQ] per-requester operand valid
//   req_ready  - [NUM_REQ] per-requester accept (at most one high)
//   req_ain    - [NUM_REQ*27] signed operand A, requester i at [27*i +: 27]
//   req_bin    - [NUM_REQ*19] signed operand B, requester i at [19*i +: 19]
//   m_ain      - [27] registered operand A to the shared multiplier
//   m_bin      - [19] registered operand B to the shared multiplier
//   m_pout     - [46] signed product returned by the shared multiplier
//   rsp_valid  - [NUM_REQ] one-hot result strobe to the owning requester
//   rsp_pout   - [46] product, qualified by rsp_valid, otherwise 0
//   inflight   - [3] accepted operations not yet returned
// ---------------------------------------------------------------------------
module mult_27x19_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int MULT_LATENCY = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*27-1:0] req_ain,
  input  logic [NUM_REQ*19-1:0] req_bin,
  output logic [26:0]          m_ain,
  output logic [18:0]          m_bin,
  input  logic [45:0]          m_pout,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [45:0]          rsp_pout,
  output logic [2:0]           inflight
);

  localparam int IW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DEPTH = MULT_LATENCY + 1;

  logic [IW-1:0] r_ptr;
  logic [26:0]   r_ain;
  logic [18:0]   r_bin;
  logic [2:0]    r_inflight;
  logic          r_tagValid [DEPTH];
  logic [IW-1:0] r_tagIdx   [DEPTH];

  logic          w_grantValid;
  logic [IW-1:0] w_grantIdx;
  logic [IW-1:0] w_nextPtr;
  logic [26:0]   w_selA;
  logic [18:0]   w_selB;
  logic          w_xfer;
  logic          w_rspFire;

  // Round-robin search: walk the requesters starting at the pointer and stop
  // at the first one that is valid. Only req_valid and the pointer feed this,
  // so readiness never depends on operand data.
  always_comb begin
    int cand;
    w_grantValid = 1'b0;
    w_grantIdx   = '0;
    cand         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(r_ptr) + k) % NUM_REQ;
      if (!w_grantValid && req_valid[IW'(cand)]) begin
        w_grantValid = 1'b1;
        w_grantIdx   = IW'(cand);
      end
    end
  end

  // A grant always lands on a valid requester, so a grant outside reset is
  // a transfer. The pointer moves to the slot after the winner, wrapping.
  assign w_xfer    = w_grantValid && !rst;
  assign w_nextPtr = (w_grantIdx == IW'(NUM_REQ - 1)) ? '0 : w_grantIdx + 1'b1;

  // Decode the grant into the one-hot ready vector and pick out the winner's
  // operands for registering toward the multiplier.
  always_comb begin
    req_ready = '0;
    w_selA    = '0;
    w_selB    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_xfer && (w_grantIdx == IW'(i))) begin
        req_ready[i] = 1'b1;
        w_selA       = req_ain[27*i +: 27];
        w_selB       = req_bin[19*i +: 19];
      end
    end
  end

  // The oldest tag stage lines up with the cycle the multiplier presents the
  // matching product on m_pout.
  assign w_rspFire = r_tagValid[MULT_LATENCY] && !rst;

  // Operand registers, pointer, tag pipeline and in-flight counter. Idle
  // cycles drive zeros to the multiplier so its pipeline carries no stale
  // operands. Reset clears every tag valid, which is what discards any
  // operation already in the multiplier.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= '0;
      r_ain      <= '0;
      r_bin      <= '0;
      r_inflight <= '0;
      for (int s = 0; s < DEPTH; s++) begin
        r_tagValid[s] <= 1'b0;
        r_tagIdx[s]   <= '0;
      end
    end else begin
      if (w_xfer) begin
        r_ptr <= w_nextPtr;
        r_ain <= w_selA;
        r_bin <= w_selB;
      end else begin
        r_ain <= '0;
        r_bin <= '0;
      end
      r_tagValid[0] <= w_xfer;
      r_tagIdx[0]   <= w_grantIdx;
      for (int s = 1; s < DEPTH; s++) begin
        r_tagValid[s] <= r_tagValid[s-1];
        r_tagIdx[s]   <= r_tagIdx[s-1];
      end
      case ({w_xfer, w_rspFire})
        2'b10:   r_inflight <= r_inflight + 3'd1;
        2'b01:   r_inflight <= r_inflight - 3'd1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // Response strobe goes to the requester recorded in the oldest tag stage;
  // the product is passed through unchanged and forced to 0 otherwise.
  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_rspFire && (r_tagIdx[MULT_LATENCY] == IW'(i))) begin
        rsp_valid[i] = 1'b1;
      end
    end
  end

  assign rsp_pout = w_rspFire ? m_pout : '0;

  // Outputs read as zero for every cycle rst is high, including the first
  // one, before the registers have actually been cleared.
  assign m_ain    = rst ? '0 : r_ain;
  assign m_bin    = rst ? '0 : r_bin;
  assign inflight = rst ? '0 : r_inflight;

endmodule

// File: doc/mult_27x19_arbiter.md
MULT_27X19_ARBITER -- requirements
Module: mult_27x19_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter MULT_LATENCY, default 3, giving the cycles from multiplier operand sample to valid m_pout.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-005 The block SHALL have port req_valid, input, NUM_REQ bits, per-requester operand valid.
REQ-006 The block SHALL have port req_ready, output, NUM_REQ bits, per-requester accept; at most one bit high per cycle.
REQ-007 The block SHALL have port req_ain, input, NUM_REQ*27 bits, signed 27-bit operand per requester (requester i at [27*i +: 27]).
REQ-008 The block SHALL have port req_bin, input, NUM_REQ*19 bits, signed 19-bit operand per requester (requester i at [19*i +: 19]).
REQ-009 The block SHALL have port m_ain, output, 27 bits, registered operand A to the shared multiplier.
REQ-010 The block SHALL have port m_bin, output, 19 bits, registered operand B to the shared multiplier.
REQ-011 The block SHALL have port m_pout, input, 46 bits, signed product from the shared multiplier.
REQ-012 The block SHALL have port rsp_valid, output, NUM_REQ bits, one-hot result strobe to the owning requester.
REQ-013 The block SHALL have port rsp_pout, output, 46 bits, signed product, shared by all requesters, qualified by rsp_valid.
REQ-014 The block SHALL have port inflight, output, 3 bits, count of accepted operations not yet returned.

Function
REQ-015 Handshake: a transfer for requester i SHALL occur in a cycle where req_valid[i] and req_ready[i] are both 1; req_ready SHALL depend only on req_valid and internal state, never on data.
REQ-016 Arbitration SHALL be round-robin: pointer ptr (reset 0); grant goes to the first valid requester searching ptr, ptr+1, ... mod NUM_REQ; after a grant to i, ptr <= (i+1) mod NUM_REQ; no grant leaves ptr unchanged.
REQ-017 One operation SHALL be accepted per cycle at most; with any req_valid high and not in reset, exactly one req_ready SHALL be high (no bubbles, no stalls; results never back-pressured).
REQ-018 On a transfer at cycle T, m_ain/m_bin SHALL present the granted operands in cycle T+1; in cycles with no transfer they SHALL be driven to 0 on the next cycle.
REQ-019 A tag pipeline of depth MULT_LATENCY+1 SHALL carry {valid, requester index}, entering at cycle T.
REQ-020 The result for a transfer at cycle T SHALL appear as rsp_valid one-hot for that requester with rsp_pout = m_pout in cycle T+1+MULT_LATENCY (4 cycles with defaults); rsp_pout SHALL be 0 when no rsp_valid bit is set.
REQ-021 Results SHALL return in acceptance order; back-to-back transfers yield back-to-back responses.
REQ-022 inflight SHALL increment on transfer, decrement on response, stay unchanged on simultaneous transfer and response, never exceed MULT_LATENCY+1.
REQ-023 Arithmetic: operands and product are two's-complement; the block SHALL pass data unmodified (no sign extension, truncation or rounding).

Reset
REQ-024 While rst is 1: req_ready=0, rsp_valid=0, rsp_pout=0, m_ain=0, m_bin=0, inflight=0, ptr=0, all tag valids cleared.
REQ-025 Reset mid-operation SHALL discard in-flight operations: no rsp_valid for any transfer accepted before rst, even though m_pout still carries old products.
REQ-026 The first cycle after rst deasserts SHALL allow a transfer (requester 0 has priority).

Verification
REQ-027 Single op: after reset, req_valid[2]=1, ain=-3, bin=5 for one transfer -> ready[2] same cycle; m_ain=-3, m_bin=5 next cycle; rsp_valid=4'b0100, rsp_pout=-15 four cycles after transfer; inflight 1 then 0.
REQ-028 Full contention: all four req_valid held high 8 cycles -> grants 0,1,2,3,0,1,2,3; responses in same order, 4 cycles lagged, one per cycle; inflight settles at 4.
REQ-029 Pointer wrap: grant to 3 with only 1 and 3 valid afterwards -> next grant 1, then 3.
REQ-030 Extremes: ain=-2^26, bin=-2^18 -> rsp_pout=+2^44; ain=2^26-1, bin=-1 -> rsp_pout=-(2^26-1).
REQ-031 Reset mid-flight: three transfers accepted, rst pulsed 1 cycle at next cycle -> no rsp_valid within following 6 cycles; inflight=0; next request served with correct product.
REQ-032 Idle: all req_valid=0 for 10 cycles -> req_ready=0, rsp_valid=0, m_ain=m_bin=0, ptr unchanged.
